// File: rtl/grant_decoder_2x4_if.sv
// rtl/grant_decoder_2x4_if.sv - encoder-side request and grant bundle for grant_decoder_2x4
// Optional GRANT_COUNT_EN adds grant_cnt to the bundle.
interface grant_decoder_2x4_if;
  logic       z;
  logic [1:0] y;
  logic       ack;
  logic [3:0] g;
  logic       busy;
  logic       timeout;
`ifdef GRANT_COUNT_EN
  logic [7:0] grant_cnt;

  modport master (
    output z, y, ack,
    input  g, busy, timeout, grant_cnt
  );

  modport slave (
    input  z, y, ack,
    output g, busy, timeout, grant_cnt
  );
`else
  modport master (
    output z, y, ack,
    input  g, busy, timeout
  );

  modport slave (
    input  z, y, ack,
    output g, busy, timeout
  );
`endif
endinterface

// File: rtl/grant_decoder_2x4.sv
// rtl/grant_decoder_2x4.sv - registered one-hot grant from a {z, y} priority code with ack/timer release
// Optional GRANT_COUNT_EN adds an 8-bit wrapping count of issued grants.
module grant_decoder_2x4 #(
  parameter int HOLD_CYCLES = 8,
  parameter int CW          = 8
) (
  input logic                clk,
  input logic                reset_n,
  grant_decoder_2x4_if.slave gd
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  state_t        r_state;
  state_t        w_state_nx;
  logic [1:0]    r_code;
  logic [1:0]    w_code_nx;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;
  logic [3:0]    r_g;
  logic [3:0]    w_g_nx;
  logic          r_busy;
  logic          w_busy_nx;
  logic          r_timeout;
  logic          w_timeout_nx;
  logic          w_accept;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_code    <= 2'd0;
      r_cnt     <= '0;
      r_g       <= 4'b0000;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_code    <= w_code_nx;
      r_cnt     <= w_cnt_nx;
      r_g       <= w_g_nx;
      r_busy    <= w_busy_nx;
      r_timeout <= w_timeout_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_code_nx    = r_code;
    w_cnt_nx     = r_cnt;
    w_g_nx       = 4'b0000;
    w_busy_nx    = 1'b0;
    w_timeout_nx = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (gd.z) begin
          w_accept   = 1'b1;
          w_state_nx = ST_GRANT;
          w_code_nx  = gd.y;
          w_cnt_nx   = '0;
          w_g_nx     = 4'b0001 << gd.y;
          w_busy_nx  = 1'b1;
        end
      end
      ST_GRANT: begin
        // Grant is rebuilt from the latched code; z/y are deliberately not looked at here.
        w_g_nx    = 4'b0001 << r_code;
        w_busy_nx = 1'b1;
        if (gd.ack) begin
          w_state_nx = ST_GAP;
          w_g_nx     = 4'b0000;
        end else if (r_cnt == HOLD_LAST) begin
          w_state_nx   = ST_GAP;
          w_g_nx       = 4'b0000;
          w_timeout_nx = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      ST_GAP: begin
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

`ifdef GRANT_COUNT_EN
  logic [7:0] r_grant_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grant_cnt <= 8'd0;
    end else if (w_accept) begin
      r_grant_cnt <= r_grant_cnt + 8'd1;
    end
  end

  assign gd.grant_cnt = r_grant_cnt;
`endif

  assign gd.g       = r_g;
  assign gd.busy    = r_busy;
  assign gd.timeout = r_timeout;

endmodule

// File: tb/tb_grant_decoder_2x4.sv
// tb/tb_grant_decoder_2x4.sv - directed stimulus with a cycle-level grant model and literal spot checks
`timescale 1ns/100ps
module tb_grant_decoder_2x4;
  localparam int HOLD = 8;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp   = 0;
  int   n_err   = 0;

  grant_decoder_2x4_if gd_if ();

  grant_decoder_2x4 #(.HOLD_CYCLES(HOLD), .CW(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .gd      (gd_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the grant, how many cycles it has been shown, and cooldown cycles left.
  int m_owner = -1;
  int m_age   = 0;
  int m_cool  = 0;
  bit m_to    = 1'b0;
  int m_cnt   = 0;

  always @(posedge clk or negedge reset_n) begin : model
    int o, a, c, n;
    bit t;
    if (!reset_n) begin
      m_owner <= -1;
      m_age   <= 0;
      m_cool  <= 0;
      m_to    <= 1'b0;
      m_cnt   <= 0;
    end else begin
      o = m_owner; a = m_age; c = m_cool; n = m_cnt; t = 1'b0;
      if (o >= 0) begin
        a = a + 1;
        if (gd_if.ack) begin
          o = -1; c = 1;
        end else if (a >= HOLD) begin
          o = -1; c = 1; t = 1'b1;
        end
      end else if (c > 0) begin
        c = c - 1;
      end else if (gd_if.z) begin
        o = int'(gd_if.y); a = 0; n = (n + 1) % 256;
      end
      m_owner <= o;
      m_age   <= a;
      m_cool  <= c;
      m_to    <= t;
      m_cnt   <= n;
    end
  end

  logic [3:0] prev_g = 4'b0000;

  always @(negedge clk) begin : compare
    logic [3:0] eg;
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
    chk("g", gd_if.g, eg);
    chk("busy", gd_if.busy, (m_owner >= 0 || m_cool > 0));
    chk("timeout", gd_if.timeout, m_to);
    chk("onehot_or_zero", ($countones(gd_if.g) <= 1), 1);
    if (prev_g != 4'b0000 && gd_if.g != 4'b0000)
      chk("no_back_to_back", gd_if.g, prev_g);
`ifdef GRANT_COUNT_EN
    chk("grant_cnt", gd_if.grant_cnt, m_cnt[7:0]);
`endif
    prev_g = gd_if.g;
  end

  initial begin
    int n_g, n_to;
    gd_if.z   = 1'b0;
    gd_if.y   = 2'd0;
    gd_if.ack = 1'b0;
    #1;
    chk("reset_g", gd_if.g, 4'b0000);
    chk("reset_busy", gd_if.busy, 0);
    chk("reset_timeout", gd_if.timeout, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Accept y=2, release by ack after three grant cycles
    gd_if.z = 1'b1; gd_if.y = 2'b10;
    @(negedge clk);
    chk("t1_g", gd_if.g, 4'b0100);
    chk("t1_busy", gd_if.busy, 1);
    gd_if.z = 1'b0;
    repeat (2) @(negedge clk);
    gd_if.ack = 1'b1;
    @(negedge clk);
    gd_if.ack = 1'b0;
    chk("t1_g_released", gd_if.g, 4'b0000);
    chk("t1_gap_busy", gd_if.busy, 1);
    chk("t1_no_timeout", gd_if.timeout, 0);
    @(negedge clk);
    chk("t1_idle_busy", gd_if.busy, 0);
    repeat (2) @(negedge clk);

    // Timer release: exactly HOLD grant cycles, one timeout pulse with g=0
    gd_if.z = 1'b1; gd_if.y = 2'b11;
    @(negedge clk);
    gd_if.z = 1'b0;
    n_g = 0; n_to = 0;
    for (int i = 0; i < 20; i++) begin
      if (gd_if.g == 4'b1000) n_g++;
      if (gd_if.timeout) begin
        n_to++;
        chk("t2_g_at_timeout", gd_if.g, 4'b0000);
      end
      @(negedge clk);
    end
    chk("t2_grant_cycles", n_g, HOLD);
    chk("t2_timeout_pulses", n_to, 1);

    // Inputs ignored while granted
    gd_if.z = 1'b1; gd_if.y = 2'b00;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      gd_if.y = 2'b11;
      gd_if.z = ~gd_if.z;
      @(negedge clk);
      chk("t3_g_held", gd_if.g, 4'b0001);
    end
    gd_if.z = 1'b0; gd_if.ack = 1'b1;
    @(negedge clk);
    gd_if.ack = 1'b0;
    repeat (3) @(negedge clk);

    // ack on the terminal-count edge wins over the timer
    gd_if.z = 1'b1; gd_if.y = 2'b01;
    @(negedge clk);
    gd_if.z = 1'b0;
    repeat (HOLD - 1) @(negedge clk);
    chk("t5_g_last_cycle", gd_if.g, 4'b0010);
    gd_if.ack = 1'b1;
    @(negedge clk);
    gd_if.ack = 1'b0;
    chk("t5_g_released", gd_if.g, 4'b0000);
    chk("t5_no_timeout", gd_if.timeout, 0);
    repeat (3) @(negedge clk);

    // z held high while y sweeps every half period
    gd_if.z = 1'b1;
    #2.5;
    for (int i = 0; i < 32; i++) begin
      gd_if.y = 2'(i % 4);
      #5;
    end
    gd_if.z = 1'b0;
    repeat (HOLD + 4) @(negedge clk);

    // Asynchronous reset in the middle of a grant
    gd_if.z = 1'b1; gd_if.y = 2'b10;
    @(negedge clk);
    gd_if.z = 1'b0;
    chk("t6_g_before_reset", gd_if.g, 4'b0100);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_g", gd_if.g, 4'b0000);
    chk("t6_async_busy", gd_if.busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    gd_if.z = 1'b1; gd_if.y = 2'b01;
    @(negedge clk);
    gd_if.z = 1'b0;
    chk("t6_g_after_reset", gd_if.g, 4'b0010);
`ifdef GRANT_COUNT_EN
    chk("t6_grant_cnt", gd_if.grant_cnt, 8'd1);
`endif
    gd_if.ack = 1'b1;
    @(negedge clk);
    gd_if.ack = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
